// File: rtl/mmio_console_tx_pkg.sv
// Shared constants for the MMIO console transmitter: bus widths, register
// map, status bit positions and the transmit FSM state encoding.
package mmio_console_tx_pkg;

    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;

    // Register map
    localparam logic [ADDR_LEN-1:0] ADDR_CHAR   = 32'h0000_0000; // push one byte
    localparam logic [ADDR_LEN-1:0] ADDR_WORD   = 32'h0000_0004; // push four bytes, LSB first
    localparam logic [ADDR_LEN-1:0] ADDR_HALT   = 32'h0000_0008; // request halt
    localparam logic [ADDR_LEN-1:0] ADDR_STATUS = 32'h0000_000C; // status read

    // Status word layout
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_W   = 4;

    // Transmit FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/mmio_console_tx_fifo.sv
// Byte FIFO that accepts zero to four bytes per edge and pops at most one.
// The caller checks free space before pushing; this block never refuses.
module sync_fifo_byte
    import mmio_console_tx_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [2:0]          i_push_cnt,
    input  logic [DATA_LEN-1:0] i_push_data,
    input  logic                i_pop,
    output logic [7:0]          o_rd_data,
    output logic                o_full,
    output logic                o_empty,
    output logic [CW-1:0]       o_count
);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage: write the requested number of bytes into consecutive slots
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < i_push_cnt) begin
                r_mem[r_wr_ptr + PW'(k)] <= i_push_data[8*k +: 8];
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(i_push_cnt);
            r_rd_ptr <= r_rd_ptr + PW'(i_pop);
            r_count  <= r_count + CW'(i_push_cnt) - CW'(i_pop);
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;

endmodule

// File: rtl/mmio_console_tx.sv
// Memory-mapped console: byte/word writes feed a FIFO drained by an 8N1
// UART transmitter; a halt register signals end of simulation once the
// console has fully drained.
module mmio_console_tx
    import mmio_console_tx_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_LEN-1:0] dwaddr,
    input  logic [DATA_LEN-1:0] dwdata,
    input  logic [1:0]          dwsize,
    input  logic                dwe,
    input  logic [ADDR_LEN-1:0] draddr,
    output logic [DATA_LEN-1:0] drdata,
    output logic                txd,
    output logic                halt,
    output logic                overflow,
    output tx_state_e           o_dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(CLK_DIV);

    tx_state_e     r_state;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_txd;
    logic          r_halt;
    logic          r_halt_pending;
    logic          r_overflow;

    logic          w_wr_char;
    logic          w_wr_word;
    logic          w_wr_halt;
    logic [31:0]   w_free;
    logic          w_char_ok;
    logic          w_word_ok;
    logic          w_drop;
    logic [2:0]    w_push_cnt;
    logic          w_pop;
    logic          w_div_end;
    logic [7:0]    w_rd_data;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [DATA_LEN-1:0] w_count_ext;
    logic          w_unused;

    // Write size carries no meaning for this device
    assign w_unused = ^dwsize;

    // Write decode; pushes stop being accepted once halt is requested
    assign w_wr_char = dwe && (dwaddr == ADDR_CHAR) && !r_halt_pending;
    assign w_wr_word = dwe && (dwaddr == ADDR_WORD) && !r_halt_pending;
    assign w_wr_halt = dwe && (dwaddr == ADDR_HALT);

    // Free space is taken from the pre-edge count, ignoring a same-edge pop
    assign w_free     = 32'(FIFO_DEPTH) - 32'(w_count);
    assign w_char_ok  = w_wr_char && (w_free >= 32'd1);
    assign w_word_ok  = w_wr_word && (w_free >= 32'd4);
    assign w_drop     = (w_wr_char && !w_char_ok) || (w_wr_word && !w_word_ok);
    assign w_push_cnt = w_char_ok ? 3'd1 : (w_word_ok ? 3'd4 : 3'd0);

    assign w_div_end = (r_div == DW'(CLK_DIV - 1));
    assign w_pop     = !w_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_div_end));

    sync_fifo_byte #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_push_cnt  (w_push_cnt),
        .i_push_data (dwdata),
        .i_pop       (w_pop),
        .o_rd_data   (w_rd_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // Transmit FSM: start bit, 8 data bits LSB first, stop bit, chained frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_rd_data;
                        r_div   <= '0;
                        r_txd   <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_txd   <= r_shift[0];
                        r_state <= ST_DATA;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (r_bit == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (!w_empty) begin
                            r_shift <= w_rd_data;
                            r_txd   <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    // Sticky flags: overflow on any dropped push, halt once fully drained
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow     <= 1'b0;
            r_halt_pending <= 1'b0;
            r_halt         <= 1'b0;
        end else begin
            r_overflow     <= r_overflow | w_drop;
            r_halt_pending <= r_halt_pending | w_wr_halt;
            r_halt         <= r_halt | (r_halt_pending && w_empty && (r_state == ST_IDLE));
        end
    end

    assign w_count_ext = DATA_LEN'(w_count);

    // Status read path, combinational from the read address
    always_comb begin
        drdata = '0;
        if (draddr == ADDR_STATUS) begin
            drdata[STAT_BUSY] = (r_state != ST_IDLE);
            drdata[STAT_FULL] = w_full;
            drdata[STAT_OVF]  = r_overflow;
            drdata[STAT_CNT_LSB +: STAT_CNT_W] = w_count_ext[STAT_CNT_W-1:0];
        end
    end

    assign txd         = r_txd;
    assign halt        = r_halt;
    assign overflow    = r_overflow;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mmio_console_tx.sv
// Directed bench for mmio_console_tx with CLK_DIV=4, FIFO_DEPTH=8.
module tb_mmio_console_tx;
    import mmio_console_tx_pkg::*;

    logic                clk;
    logic                reset;
    logic [ADDR_LEN-1:0] dwaddr;
    logic [DATA_LEN-1:0] dwdata;
    logic [1:0]          dwsize;
    logic                dwe;
    logic [ADDR_LEN-1:0] draddr;
    logic [DATA_LEN-1:0] drdata;
    logic                txd;
    logic                halt;
    logic                overflow;
    tx_state_e           dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [39:0] cap [9];

    mmio_console_tx #(.CLK_DIV(4), .FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .dwaddr      (dwaddr),
        .dwdata      (dwdata),
        .dwsize      (dwsize),
        .dwe         (dwe),
        .draddr      (draddr),
        .drdata      (drdata),
        .txd         (txd),
        .halt        (halt),
        .overflow    (overflow),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected 40-sample txd waveform of one frame; bit k is sample k
    function automatic logic [39:0] frame_of(input logic [7:0] b);
        logic [39:0] f;
        for (int k = 0; k < 40; k++) begin
            if (k < 4)       f[k] = 1'b0;
            else if (k < 36) f[k] = b[(k - 4) / 4];
            else             f[k] = 1'b1;
        end
        return f;
    endfunction

    // One bus write; returns 1 time unit after the write edge
    task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data);
        dwaddr = addr;
        dwdata = data;
        dwsize = 2'($urandom_range(0, 3));
        dwe    = 1'b1;
        @(posedge clk);
        #1;
        dwe    = 1'b0;
        dwaddr = '0;
        dwdata = '0;
    endtask

    // Sample txd on the next 40 clock cycles
    task automatic capture_frame(output logic [39:0] c);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            c[k] = txd;
        end
    endtask

    // Count how many of the next n cycles show txd high
    task automatic count_high(input int n, output int ones);
        ones = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (txd === 1'b1) ones++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        dwe    = 1'b0;
        dwaddr = '0;
        dwdata = '0;
        dwsize = '0;
        draddr = ADDR_STATUS;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({txd, halt, overflow} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_outputs: txd/halt/ovf=%b expected 100", {txd, halt, overflow});
        end
        n_vec++;
        if (drdata !== 32'h0 || dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_status: drdata=%h state=%0d expected 0/IDLE", drdata, dbg_state);
        end
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignored();
        int ones;
        mmio_write(32'h10, 32'h41);
        n_vec++;
        if (drdata !== 32'h0 || dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL ignored_addr: drdata=%h state=%0d expected 0/IDLE", drdata, dbg_state);
        end
        dwaddr = ADDR_CHAR;
        dwdata = 32'h41;
        dwe    = 1'b0;
        @(posedge clk);
        #1;
        dwdata = '0;
        count_high(45, ones);
        n_vec++;
        if (ones != 45 || drdata !== 32'h0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ignored_dwe0: high=%0d drdata=%h ovf=%b expected 45/0/0", ones, drdata, overflow);
        end
    endtask

    task automatic test_char();
        mmio_write(ADDR_CHAR, 32'hFFFF_FF41);
        n_vec++;
        if (txd !== 1'b1 || drdata !== 32'h0000_0100) begin
            n_err++;
            $display("FAIL char_after_write: txd=%b drdata=%h expected 1/00000100", txd, drdata);
        end
        capture_frame(cap[0]);
        n_vec++;
        if (cap[0] !== 40'hF0F00000F0) begin
            n_err++;
            $display("FAIL char_frame: got %h expected F0F00000F0", cap[0]);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (drdata !== 32'h0 || txd !== 1'b1) begin
            n_err++;
            $display("FAIL char_idle_after: drdata=%h txd=%b expected 0/1", drdata, txd);
        end
    endtask

    task automatic test_word();
        logic [7:0] b;
        mmio_write(ADDR_WORD, 32'h6463_6261);
        n_vec++;
        if (drdata !== 32'h0000_0400) begin
            n_err++;
            $display("FAIL word_count: drdata=%h expected 00000400", drdata);
        end
        for (int i = 0; i < 4; i++) capture_frame(cap[i]);
        for (int i = 0; i < 4; i++) begin
            b = 8'h61 + 8'(i);
            n_vec++;
            if (cap[i] !== frame_of(b)) begin
                n_err++;
                $display("FAIL word_frame%0d: got %h expected %h", i, cap[i], frame_of(b));
            end
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (drdata !== 32'h0) begin
            n_err++;
            $display("FAIL word_idle_after: drdata=%h expected 0", drdata);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        mmio_write(ADDR_CHAR, 32'h61);
        fork
            begin
                for (int i = 1; i < 10; i++) mmio_write(ADDR_CHAR, 32'h61 + i);
                n_vec++;
                if (drdata !== 32'h0000_0807 || overflow !== 1'b1) begin
                    n_err++;
                    $display("FAIL ovf_status: drdata=%h ovf=%b expected 00000807/1", drdata, overflow);
                end
                draddr = ADDR_HALT;
                #1;
                n_vec++;
                if (drdata !== 32'h0) begin
                    n_err++;
                    $display("FAIL read_other_addr: drdata=%h expected 0", drdata);
                end
                draddr = ADDR_STATUS;
            end
            begin
                for (int i = 0; i < 9; i++) capture_frame(cap[i]);
            end
        join
        for (int i = 0; i < 9; i++) begin
            b = 8'h61 + 8'(i);
            n_vec++;
            if (cap[i] !== frame_of(b)) begin
                n_err++;
                $display("FAIL ovf_frame%0d: got %h expected %h", i, cap[i], frame_of(b));
            end
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (drdata !== 32'h0000_0004) begin
            n_err++;
            $display("FAIL ovf_drained: drdata=%h expected 00000004", drdata);
        end
    endtask

    task automatic test_reset_mid_frame();
        int ones;
        do_reset();
        n_vec++;
        if (overflow !== 1'b0 || drdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_clears: ovf=%b drdata=%h expected 0/0", overflow, drdata);
        end
        mmio_write(ADDR_CHAR, 32'h41);
        mmio_write(ADDR_CHAR, 32'h42);
        repeat (13) @(posedge clk);
        #1;
        n_vec++;
        if (txd !== 1'b0 || dbg_state !== ST_DATA) begin
            n_err++;
            $display("FAIL mid_bit2: txd=%b state=%0d expected 0/DATA", txd, dbg_state);
        end
        #3;
        reset = 1'b1;
        #1;
        n_vec++;
        if (txd !== 1'b1 || drdata !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: txd=%b drdata=%h expected 1/0", txd, drdata);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        count_high(50, ones);
        n_vec++;
        if (ones != 50 || drdata !== 32'h0) begin
            n_err++;
            $display("FAIL no_residual: high=%0d drdata=%h expected 50/0", ones, drdata);
        end
    endtask

    task automatic test_halt();
        int ones;
        mmio_write(ADDR_CHAR, 32'h41);
        fork
            mmio_write(ADDR_HALT, 32'h1);
            capture_frame(cap[0]);
        join
        n_vec++;
        if (cap[0] !== 40'hF0F00000F0 || halt !== 1'b0) begin
            n_err++;
            $display("FAIL halt_frame: got %h halt=%b expected F0F00000F0/0", cap[0], halt);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (halt !== 1'b1) begin
            n_err++;
            $display("FAIL halt_rise: halt=%b expected 1", halt);
        end
        mmio_write(ADDR_CHAR, 32'h42);
        count_high(45, ones);
        n_vec++;
        if (ones != 45 || halt !== 1'b1 || drdata !== 32'h0) begin
            n_err++;
            $display("FAIL halt_blocks_push: high=%0d halt=%b drdata=%h expected 45/1/0", ones, halt, drdata);
        end
    endtask

    initial begin
        test_reset();
        test_ignored();
        test_char();
        test_word();
        test_overflow();
        test_reset_mid_frame();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
